// File: rtl/rf_read_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// rf_read_port_arbiter_pkg
// Shared definitions for the register-file read-port arbiter:
//   - arb_state_e     : arbiter FSM state encoding (IDLE / SEL)
//   - RF_ARB_*        : default widths and requester count
//   - rr_next_idx()   : round-robin successor of a requester index
// -----------------------------------------------------------------------------
package rf_read_port_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEL  = 1'b1
    } arb_state_e;

    localparam int RF_ARB_NUM_REQ = 4;
    localparam int RF_ARB_ADDR_W  = 5;
    localparam int RF_ARB_DATA_W  = 32;

    // Index following idx in a ring of n requesters.
    function automatic int unsigned rr_next_idx(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rf_read_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// rf_read_port_arbiter_if
// Bundles the requester handshake and the external read-mux connection.
//   REQ       : per-requester read request (level)
//   REQ_ADDR  : packed register indices, requester i at [i*ADDR_W +: ADDR_W]
//   GNT       : one-hot, one-cycle grant pulse
//   MUX_S     : select driven to the external 32:1 mux
//   MUX_Y     : data returned by the external mux
//   RD_DATA   : captured read data
//   RD_VALID  : one-hot, one-cycle; RD_DATA belongs to that requester
//   BUSY      : high while the arbiter is in its SEL state
// Modports: slave = the arbiter, master = requesters plus the mux.
// -----------------------------------------------------------------------------
interface rf_read_port_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32
) ();
    logic [NUM_REQ-1:0]        REQ;
    logic [NUM_REQ*ADDR_W-1:0] REQ_ADDR;
    logic [NUM_REQ-1:0]        GNT;
    logic [ADDR_W-1:0]         MUX_S;
    logic [DATA_W-1:0]         MUX_Y;
    logic [DATA_W-1:0]         RD_DATA;
    logic [NUM_REQ-1:0]        RD_VALID;
    logic                      BUSY;

    modport slave (
        input  REQ, REQ_ADDR, MUX_Y,
        output GNT, MUX_S, RD_DATA, RD_VALID, BUSY
    );

    modport master (
        output REQ, REQ_ADDR, MUX_Y,
        input  GNT, MUX_S, RD_DATA, RD_VALID, BUSY
    );
endinterface

// File: rtl/MUX32_32x1.sv
// -----------------------------------------------------------------------------
// MUX32_32x1
// Behavioural model of the register-file read mux: 32 inputs of 32 bits,
// 5-bit select.
//   I : 32 x 32-bit data inputs
//   S : select
//   Y : I[S]
// -----------------------------------------------------------------------------
module MUX32_32x1 (
    input  logic [31:0] I [32],
    input  logic [4:0]  S,
    output logic [31:0] Y
);
    assign Y = I[S];
endmodule

// File: rtl/rf_read_port_arbiter_picker.sv
// -----------------------------------------------------------------------------
// rr_priority_picker
// Combinational round-robin picker: finds the first set request bit at or
// above ptr_i, wrapping at NUM_REQ.
//   req_i     : request vector
//   ptr_i     : index holding highest priority
//   win_o     : one-hot winner (all zero when no request)
//   win_idx_o : binary winner index (don't-care when no request)
// -----------------------------------------------------------------------------
module rr_priority_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] win_o,
    output logic [IDX_W-1:0]   win_idx_o
);
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [IDX_W-1:0]     first;
    logic [IDX_W:0]       sum;
    logic                 found;

    always_comb begin
        // Rotate right by ptr so the priority holder lands at bit 0.
        dbl   = {req_i, req_i} >> ptr_i;
        rot   = dbl[NUM_REQ-1:0];
        found = 1'b0;
        first = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                first = IDX_W'(i);
            end
        end
        // Rotate back: offset plus ptr, modulo NUM_REQ.
        sum = {1'b0, first} + {1'b0, ptr_i};
        if (sum >= (IDX_W+1)'(NUM_REQ)) begin
            sum = sum - (IDX_W+1)'(NUM_REQ);
        end
        win_idx_o = sum[IDX_W-1:0];
        win_o     = found ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx_o) : '0;
    end
endmodule

// File: rtl/rf_read_port_arbiter.sv
// -----------------------------------------------------------------------------
// rf_read_port_arbiter
// Shares one register-file read port among NUM_REQ requesters with
// round-robin priority. A read takes two cycles: the IDLE edge picks a winner
// and drives its register index onto MUX_S; the SEL edge captures MUX_Y into
// RD_DATA and pulses RD_VALID for that requester.
// Ports:
//   CLK : clock, rising edge
//   RST : synchronous active-high reset; wins over every other update
//   bus : rf_read_port_arbiter_if.slave (REQ, REQ_ADDR, GNT, MUX_S, MUX_Y,
//         RD_DATA, RD_VALID, BUSY)
// -----------------------------------------------------------------------------
module rf_read_port_arbiter
    import rf_read_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ = RF_ARB_NUM_REQ,
    parameter int ADDR_W  = RF_ARB_ADDR_W,
    parameter int DATA_W  = RF_ARB_DATA_W
) (
    input logic                   CLK,
    input logic                   RST,
    rf_read_port_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_e          state_q,    state_d;
    logic [IDX_W-1:0]    ptr_q,      ptr_d;
    logic [IDX_W-1:0]    win_idx_q,  win_idx_d;
    logic [NUM_REQ-1:0]  gnt_q,      gnt_d;
    logic [NUM_REQ-1:0]  rd_valid_q, rd_valid_d;
    logic [ADDR_W-1:0]   mux_s_q,    mux_s_d;
    logic [DATA_W-1:0]   rd_data_q,  rd_data_d;

    logic [NUM_REQ-1:0]  win;
    logic [IDX_W-1:0]    win_idx;
    logic [ADDR_W-1:0]   win_addr;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req_i     (bus.REQ),
        .ptr_i     (ptr_q),
        .win_o     (win),
        .win_idx_o (win_idx)
    );

    // Register index of the current winner.
    always_comb begin
        win_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IDX_W'(i)) begin
                win_addr = bus.REQ_ADDR[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        win_idx_d  = win_idx_q;
        gnt_d      = '0;
        rd_valid_d = '0;
        mux_s_d    = mux_s_q;
        rd_data_d  = rd_data_q;
        case (state_q)
            ST_IDLE: begin
                // MUX_S moves only here, so Y is settled for the whole SEL cycle.
                if (|bus.REQ) begin
                    mux_s_d   = win_addr;
                    gnt_d     = win;
                    win_idx_d = win_idx;
                    state_d   = ST_SEL;
                end
            end
            ST_SEL: begin
                // REQ is ignored here; gnt_q still holds the winner one-hot.
                rd_data_d  = bus.MUX_Y;
                rd_valid_d = gnt_q;
                ptr_d      = IDX_W'(rr_next_idx(32'(win_idx_q), NUM_REQ));
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            win_idx_q  <= '0;
            gnt_q      <= '0;
            rd_valid_q <= '0;
            mux_s_q    <= '0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            win_idx_q  <= win_idx_d;
            gnt_q      <= gnt_d;
            rd_valid_q <= rd_valid_d;
            mux_s_q    <= mux_s_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign bus.GNT      = gnt_q;
    assign bus.RD_VALID = rd_valid_q;
    assign bus.MUX_S    = mux_s_q;
    assign bus.RD_DATA  = rd_data_q;
    assign bus.BUSY     = (state_q == ST_SEL);
endmodule
